// File: rtl/fifo_pkg.sv
// Shared defaults and pointer sizing for the synchronous FIFO.
package fifo_pkg;

  localparam int DEF_DEPTH      = 8;
  localparam int DEF_DATA_WIDTH = 8;

  // Address bits plus one wrap bit to tell full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one write port and one registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO: wrap-bit pointers, combinational flags, one-cycle registered read.
module synchronous_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int AW    = PTR_W - 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             wr_acc, rd_acc;

  // Same slot with differing wrap bits means the writer is a full lap ahead.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .rst_i   (rst_n),
    .we_i    (wr_acc && !rst_n),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (data_in),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (data_out)
  );

endmodule

// File: tb/tb_synchronous_fifo.sv
// Directed self-checking bench for synchronous_fifo (DEPTH=8, DATA_WIDTH=8).
module tb_synchronous_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       full, empty;

  int total_cnt = 0;
  int pass_cnt  = 0;

  synchronous_fifo #(.DEPTH(8), .DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_en     (w_en),
    .r_en     (r_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    w_en = 1'b1; data_in = d;
    tick();
    w_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    total_cnt++;
    if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else pass_cnt++;
    total_cnt++;
    if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else pass_cnt++;
    total_cnt++;
    if (data_out !== 8'h00) $display("FAIL reset_dout got %h want 00", data_out); else pass_cnt++;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      push(8'h11 + 8'(i));
      if (i == 6) begin
        total_cnt++;
        if (full !== 1'b0) $display("FAIL fill_full_at7 got %b want 0", full); else pass_cnt++;
      end
    end
    total_cnt++;
    if (full !== 1'b1) $display("FAIL fill_full got %b want 1", full); else pass_cnt++;
    total_cnt++;
    if (data_out !== 8'h00) $display("FAIL fill_dout_hold got %h want 00", data_out); else pass_cnt++;
    r_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total_cnt++;
      if (data_out !== 8'h11 + 8'(i))
        $display("FAIL drain_dout[%0d] got %h want %h", i, data_out, 8'h11 + 8'(i));
      else pass_cnt++;
    end
    r_en = 1'b0;
    total_cnt++;
    if (empty !== 1'b1) $display("FAIL drain_empty got %b want 1", empty); else pass_cnt++;
  endtask

  task automatic test_write_full();
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    push(8'hAA);
    total_cnt++;
    if (full !== 1'b1) $display("FAIL wfull_full got %b want 1", full); else pass_cnt++;
    r_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total_cnt++;
      if (data_out !== 8'h11 + 8'(i))
        $display("FAIL wfull_dout[%0d] got %h want %h", i, data_out, 8'h11 + 8'(i));
      else pass_cnt++;
    end
    total_cnt++;
    if (empty !== 1'b1) $display("FAIL wfull_empty got %b want 1", empty); else pass_cnt++;
    // A ninth read must find nothing (the dropped AA must not appear).
    tick();
    r_en = 1'b0;
    total_cnt++;
    if (data_out !== 8'h18) $display("FAIL wfull_extra got %h want 18", data_out); else pass_cnt++;
  endtask

  task automatic test_read_empty();
    r_en = 1'b1;
    tick();
    tick();
    r_en = 1'b0;
    total_cnt++;
    if (data_out !== 8'h18) $display("FAIL rempty_dout got %h want 18", data_out); else pass_cnt++;
    total_cnt++;
    if (empty !== 1'b1) $display("FAIL rempty_empty got %b want 1", empty); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    push(8'h21); push(8'h22); push(8'h23);
    w_en = 1'b1; r_en = 1'b1; data_in = 8'h55;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    total_cnt++;
    if (data_out !== 8'h21) $display("FAIL simul_dout got %h want 21", data_out); else pass_cnt++;
    r_en = 1'b1;
    tick();
    total_cnt++;
    if (data_out !== 8'h22) $display("FAIL simul_d1 got %h want 22", data_out); else pass_cnt++;
    tick();
    total_cnt++;
    if (data_out !== 8'h23) $display("FAIL simul_d2 got %h want 23", data_out); else pass_cnt++;
    total_cnt++;
    if (empty !== 1'b0) $display("FAIL simul_occ3 got empty %b want 0", empty); else pass_cnt++;
    tick();
    r_en = 1'b0;
    total_cnt++;
    if (data_out !== 8'h55) $display("FAIL simul_d3 got %h want 55", data_out); else pass_cnt++;
    total_cnt++;
    if (empty !== 1'b1) $display("FAIL simul_empty got %b want 1", empty); else pass_cnt++;
  endtask

  task automatic test_simul_edges();
    // Both while empty: only the write happens.
    w_en = 1'b1; r_en = 1'b1; data_in = 8'h66;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    total_cnt++;
    if (data_out !== 8'h55) $display("FAIL se_empty_dout got %h want 55", data_out); else pass_cnt++;
    total_cnt++;
    if (empty !== 1'b0) $display("FAIL se_empty_flag got %b want 0", empty); else pass_cnt++;
    for (int i = 0; i < 7; i++) push(8'h70 + 8'(i));
    // Both while full: only the read happens, full drops.
    w_en = 1'b1; r_en = 1'b1; data_in = 8'h99;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    total_cnt++;
    if (data_out !== 8'h66) $display("FAIL se_full_dout got %h want 66", data_out); else pass_cnt++;
    total_cnt++;
    if (full !== 1'b0) $display("FAIL se_full_flag got %b want 0", full); else pass_cnt++;
    r_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      total_cnt++;
      if (data_out !== 8'h70 + 8'(i))
        $display("FAIL se_drain[%0d] got %h want %h", i, data_out, 8'h70 + 8'(i));
      else pass_cnt++;
    end
    r_en = 1'b0;
    total_cnt++;
    if (empty !== 1'b1) $display("FAIL se_drain_empty got %b want 1", empty); else pass_cnt++;
  endtask

  task automatic test_wrap_and_reset();
    for (int i = 0; i < 5; i++) push(8'h31 + 8'(i));
    r_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (data_out !== 8'h31 + 8'(i))
        $display("FAIL wrap_rd[%0d] got %h want %h", i, data_out, 8'h31 + 8'(i));
      else pass_cnt++;
    end
    r_en = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h36 + 8'(i));
    r_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      total_cnt++;
      if (data_out !== 8'h35 + 8'(i))
        $display("FAIL wrap_drain[%0d] got %h want %h", i, data_out, 8'h35 + 8'(i));
      else pass_cnt++;
    end
    r_en = 1'b0;
    total_cnt++;
    if (empty !== 1'b1) $display("FAIL wrap_empty got %b want 1", empty); else pass_cnt++;
    for (int i = 0; i < 4; i++) push(8'h41 + 8'(i));
    // Reset with a write and read also requested: reset must win.
    rst_n = 1'b1; w_en = 1'b1; r_en = 1'b1; data_in = 8'hEE;
    tick();
    rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0;
    total_cnt++;
    if (empty !== 1'b1) $display("FAIL rst_mid_empty got %b want 1", empty); else pass_cnt++;
    total_cnt++;
    if (full !== 1'b0) $display("FAIL rst_mid_full got %b want 0", full); else pass_cnt++;
    total_cnt++;
    if (data_out !== 8'h00) $display("FAIL rst_mid_dout got %h want 00", data_out); else pass_cnt++;
    push(8'h5A);
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    total_cnt++;
    if (data_out !== 8'h5A) $display("FAIL post_rst_dout got %h want 5a", data_out); else pass_cnt++;
    total_cnt++;
    if (empty !== 1'b1) $display("FAIL post_rst_empty got %b want 1", empty); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_write_full();
    test_read_empty();
    test_simultaneous();
    test_simul_edges();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
